// File: rtl/sda_line_ctrl_if.sv
// Command/bus bundle between the I2C controller FSM and the SDA line sequencer.
// Optional arbitration signals appear when SDA_ARB_DETECT_EN is defined.
interface sda_line_ctrl_if #(
  parameter int MODE_W = 3
);
  logic              scl_in;
  logic              tx_out;
  logic [MODE_W-1:0] sda_mode;
  logic              mode_valid;
  logic              mode_ready;
  logic              busy;
  logic              sda_out;
`ifdef SDA_ARB_DETECT_EN
  logic              sda_in;
  logic              arb_lost;

  modport master (
    output scl_in, tx_out, sda_mode, mode_valid, sda_in,
    input  mode_ready, busy, sda_out, arb_lost
  );

  modport slave (
    input  scl_in, tx_out, sda_mode, mode_valid, sda_in,
    output mode_ready, busy, sda_out, arb_lost
  );
`else
  modport master (
    output scl_in, tx_out, sda_mode, mode_valid,
    input  mode_ready, busy, sda_out
  );

  modport slave (
    input  scl_in, tx_out, sda_mode, mode_valid,
    output mode_ready, busy, sda_out
  );
`endif
endinterface

// File: rtl/sda_line_ctrl.sv
// Sequenced SDA driver: moves SDA only in the legal SCL phase after a hold time.
// Optional multi-master arbitration-loss detection under SDA_ARB_DETECT_EN.
module sda_line_ctrl #(
  parameter int HOLD_CYCLES = 3,
  parameter int MODE_W      = 3
) (
  input  logic           clk,
  input  logic           rst,
  sda_line_ctrl_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    READY,
    WAIT_LOW,
    HOLD_LOW,
    WAIT_HIGH,
    HOLD_HIGH
  } state_t;

  typedef enum logic [2:0] {
    M_IDLE    = 3'd0,
    M_LOW     = 3'd1,
    M_RELEASE = 3'd2,
    M_TX      = 3'd3,
    M_START   = 3'd4,
    M_STOP    = 3'd5
  } mode_t;

  state_t           r_state;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sda;

  logic [MODE_W-1:0] w_cmd;
  mode_t             w_mode;
  logic              w_levelVal;
  logic              w_accept;

  assign w_cmd    = bus.sda_mode;
  assign w_accept = (r_state == READY) && bus.mode_valid;

  // Reserved codes and any nonzero upper bit collapse to IDLE.
  always_comb begin
    w_mode = M_IDLE;
    if ((w_cmd >> 3) == '0) begin
      case (w_cmd[2:0])
        3'd1:    w_mode = M_LOW;
        3'd2:    w_mode = M_RELEASE;
        3'd3:    w_mode = M_TX;
        3'd4:    w_mode = M_START;
        3'd5:    w_mode = M_STOP;
        default: w_mode = M_IDLE;
      endcase
    end
  end

  always_comb begin
    w_levelVal = 1'b1;
    case (r_mode)
      M_LOW:   w_levelVal = 1'b0;
      M_STOP:  w_levelVal = 1'b0;
      M_TX:    w_levelVal = bus.tx_out;
      default: w_levelVal = 1'b1;
    endcase
  end

`ifdef SDA_ARB_DETECT_EN
  logic r_arb;
  logic w_arbHit;

  assign w_arbHit = r_sda && !bus.sda_in && bus.scl_in &&
                    (((r_state == READY) && !bus.mode_valid) ||
                     (r_state == WAIT_HIGH) || (r_state == HOLD_HIGH));
  assign bus.arb_lost = r_arb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= READY;
      r_mode  <= M_IDLE;
      r_cnt   <= '0;
      r_sda   <= 1'b1;
`ifdef SDA_ARB_DETECT_EN
      r_arb   <= 1'b0;
`endif
    end else begin
      case (r_state)
        READY: begin
          if (w_accept) begin
            r_mode <= w_mode;
            r_cnt  <= '0;
`ifdef SDA_ARB_DETECT_EN
            r_arb  <= 1'b0;
`endif
            if (w_mode == M_START) begin
              r_sda   <= 1'b1;
              r_state <= WAIT_HIGH;
            end else begin
              r_state <= WAIT_LOW;
            end
          end
        end
        WAIT_LOW: begin
          if (!bus.scl_in) begin
            r_state <= HOLD_LOW;
            r_cnt   <= '0;
          end
        end
        // Losing the SCL phase restarts the hold from the wait state.
        HOLD_LOW: begin
          if (bus.scl_in) begin
            r_state <= WAIT_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_sda   <= w_levelVal;
            r_cnt   <= '0;
            r_state <= (r_mode == M_STOP) ? WAIT_HIGH : READY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (bus.scl_in) begin
            r_state <= HOLD_HIGH;
            r_cnt   <= '0;
          end
        end
        HOLD_HIGH: begin
          if (!bus.scl_in) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_sda   <= (r_mode == M_STOP);
            r_cnt   <= '0;
            r_state <= READY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= READY;
          r_cnt   <= '0;
        end
      endcase
`ifdef SDA_ARB_DETECT_EN
      // Another master pulled SDA low while we released it: back off.
      if (w_arbHit) begin
        r_arb   <= 1'b1;
        r_sda   <= 1'b1;
        r_cnt   <= '0;
        r_state <= READY;
      end
`endif
    end
  end

  assign bus.mode_ready = (r_state == READY);
  assign bus.busy       = (r_state != READY);
  assign bus.sda_out    = r_sda;

endmodule

// File: tb/tb_sda_line_ctrl.sv
// Self-checking bench for sda_line_ctrl: vector table, directed START/STOP/arbitration
// sequences, then random traffic against a phase-run reference model.
module tb_sda_line_ctrl;

  localparam int HOLD = 3;
  localparam int MW   = 4;
`ifdef SDA_ARB_DETECT_EN
  localparam bit ARB = 1'b1;
`else
  localparam bit ARB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sda_line_ctrl_if #(.MODE_W(MW)) bus ();

  sda_line_ctrl #(.HOLD_CYCLES(HOLD), .MODE_W(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nVec  = 0;
  int nMiss = 0;

  // Model: a command is a list of phases; each phase needs HOLD+2 consecutive
  // in-phase SCL samples (detect + hold + apply) before SDA takes its value.
  typedef struct {
    logic lvl;
    logic val;
    logic useTx;
  } phase_t;

  phase_t mQ[$];
  logic   mSda = 1'b1;
  logic   mArb = 1'b0;
  int     mRun = 0;

  task automatic modelStep(input logic r, input logic v, input logic [MW-1:0] m,
                           input logic s, input logic t, input logic si);
    int md;
    if (r) begin
      mSda = 1'b1; mArb = 1'b0; mRun = 0; mQ.delete();
      return;
    end
    if (mQ.size() == 0 && v) begin
      md = (int'(m) > 5) ? 0 : int'(m);
      mArb = 1'b0;
      mRun = 0;
      case (md)
        1: mQ.push_back('{1'b0, 1'b0, 1'b0});
        3: mQ.push_back('{1'b0, 1'b0, 1'b1});
        4: begin mSda = 1'b1; mQ.push_back('{1'b1, 1'b0, 1'b0}); end
        5: begin mQ.push_back('{1'b0, 1'b0, 1'b0}); mQ.push_back('{1'b1, 1'b1, 1'b0}); end
        default: mQ.push_back('{1'b0, 1'b1, 1'b0});
      endcase
      return;
    end
    if (ARB && mSda && !si && s && (mQ.size() == 0 || mQ[0].lvl)) begin
      mArb = 1'b1; mSda = 1'b1; mRun = 0; mQ.delete();
      return;
    end
    if (mQ.size() > 0) begin
      if (s == mQ[0].lvl) begin
        mRun++;
        if (mRun == HOLD + 2) begin
          mSda = mQ[0].useTx ? t : mQ[0].val;
          void'(mQ.pop_front());
          mRun = 0;
        end
      end else begin
        mRun = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [MW-1:0] m,
                               input logic s, input logic t, input logic si);
    rst            = r;
    bus.mode_valid = v;
    bus.sda_mode   = m;
    bus.scl_in     = s;
    bus.tx_out     = t;
`ifdef SDA_ARB_DETECT_EN
    bus.sda_in     = si;
`endif
    @(posedge clk);
    modelStep(r, v, m, s, t, si);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eSda, input logic eReady,
                             input logic eBusy);
    nVec++;
    if (bus.sda_out !== eSda || bus.mode_ready !== eReady || bus.busy !== eBusy) begin
      nMiss++;
      $display("[TB] FAIL %s: sda/ready/busy got %b%b%b expected %b%b%b (t=%0t)",
               name, bus.sda_out, bus.mode_ready, bus.busy, eSda, eReady, eBusy, $time);
    end
  endtask

`ifdef SDA_ARB_DETECT_EN
  task automatic checkArb(input string name, input logic eArb);
    nVec++;
    if (bus.arb_lost !== eArb) begin
      nMiss++;
      $display("[TB] FAIL %s: arb_lost got %b expected %b (t=%0t)", name, bus.arb_lost, eArb, $time);
    end
  endtask
`endif

  typedef struct {
    logic          r;
    logic          v;
    logic [MW-1:0] m;
    logic          s;
    logic          t;
    logic          eSda;
    logic          eReady;
    logic          eBusy;
    string         name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Reset with a pending LOW, then LOW dropping SCL on row 10 (applies on row 14).
    vecs.push_back('{1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "reset0"});
    vecs.push_back('{1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "reset1"});
    vecs.push_back('{1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "low_accept"});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'b0, (i == 2), 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "low_wait_scl_high"});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "low_hold"});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "low_apply"});
    // TX samples tx_out only on the apply edge.
    vecs.push_back('{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "tx_accept"});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "tx_hold"});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "tx_apply"});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "tx_keep"});
    // LOW code with an upper bit set behaves as IDLE.
    vecs.push_back('{1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "upper_accept"});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "upper_hold"});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "upper_idle_apply"});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].m, vecs[i].s, vecs[i].t, 1'b1);
      checkOutput(vecs[i].name, vecs[i].eSda, vecs[i].eReady, vecs[i].eBusy);
    end

    // START with SCL held high.
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1);
    checkOutput("start_accept", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("start_hold", 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("start_apply", 1'b0, 1'b1, 1'b0);

    // RELEASE to get SDA high before STOP.
    applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
    checkOutput("release_accept", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("release_hold", 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("release_apply", 1'b1, 1'b1, 1'b0);

    // STOP with SCL rising at hold count 1; the hold must restart.
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_accept", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("stop_hold_a", 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("stop_phase_loss", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("stop_hold_restart", 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_low_apply", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
      checkOutput("stop_high_hold", 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    checkOutput("stop_high_apply", 1'b1, 1'b1, 1'b0);

`ifdef SDA_ARB_DETECT_EN
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkArb("arb_detect", 1'b1);
    checkOutput("arb_detect_sda", 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
    checkArb("arb_clear_on_accept", 1'b0);
    checkOutput("arb_cmd_accept", 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      checkOutput("arb_idle_hold", 1'b1, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("arb_idle_apply", 1'b1, 1'b1, 1'b0);
`endif

    // Random traffic: slowly toggling SCL, sporadic commands and resets.
    begin
      logic s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic          r, v, t, si;
        logic [MW-1:0] m;
        if ($urandom_range(0, 3) == 0) s = ~s;
        r  = ($urandom_range(0, 127) == 0);
        v  = ($urandom_range(0, 2) == 0);
        m  = MW'($urandom_range(0, 15));
        t  = 1'($urandom_range(0, 1));
        si = ($urandom_range(0, 7) != 0);
        applyStimulus(r, v, m, s, t, si);
        checkOutput("random", mSda, (mQ.size() == 0), (mQ.size() != 0));
`ifdef SDA_ARB_DETECT_EN
        checkArb("random_arb", mArb);
`endif
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
